// File: rtl/rxframefilter.sv
// rxframefilter: strips and filters the Ethernet header of MAC rx frames, realigning the payload to lane 0
module rxframefilter #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   m_axi_aclk,
    input  logic                   m_axi_aresetn,
    input  logic [31:0]            RvviAxiRdata,
    input  logic [3:0]             RvviAxiRstrb,
    input  logic                   RvviAxiRlast,
    input  logic                   RvviAxiRvalid,
    input  logic                   RvviAxiRuser,
    input  logic [47:0]            DstMac,
    input  logic [47:0]            SrcMac,
    input  logic [15:0]            EthType,
    input  logic                   FilterEn,
    output logic [31:0]            PayloadData,
    output logic [3:0]             PayloadStrb,
    output logic                   PayloadValid,
    output logic                   PayloadFirst,
    output logic                   PayloadLast,
    output logic                   PayloadErr,
    output logic                   FrameDropped,
    output logic [COUNT_WIDTH-1:0] GoodFrameCount,
    output logic [COUNT_WIDTH-1:0] DropFrameCount
);
    typedef enum logic [2:0] {HDR0, HDR1, HDR2, HDR3, PAY, FLUSH, DROP} state_t;

    state_t                 r_state;
    logic [15:0]            r_hold;
    logic [1:0]             r_hold_strb;
    logic                   r_mis;
    logic                   r_first;
    logic                   r_user;
    logic [31:0]            r_pdata;
    logic [3:0]             r_pstrb;
    logic                   r_pvalid;
    logic                   r_pfirst;
    logic                   r_plast;
    logic                   r_perr;
    logic                   r_drop;
    logic [COUNT_WIDTH-1:0] r_good_cnt;
    logic [COUNT_WIDTH-1:0] r_drop_cnt;

    logic w_mis0;
    logic w_mis1;
    logic w_mis2;
    logic w_mis3;
    logic w_runt3;

    // Wire byte n sits in lane n, so each expected header word is the field bytes reversed
    assign w_mis0  = FilterEn && (RvviAxiRdata != {DstMac[23:16], DstMac[31:24], DstMac[39:32], DstMac[47:40]});
    assign w_mis1  = FilterEn && (RvviAxiRdata != {SrcMac[39:32], SrcMac[47:40], DstMac[7:0], DstMac[15:8]});
    assign w_mis2  = FilterEn && (RvviAxiRdata != {SrcMac[7:0], SrcMac[15:8], SrcMac[23:16], SrcMac[31:24]});
    assign w_mis3  = FilterEn && (RvviAxiRdata[15:0] != {EthType[7:0], EthType[15:8]});
    assign w_runt3 = RvviAxiRlast && (RvviAxiRstrb[3:2] == 2'b00);

    assign PayloadData    = r_pdata;
    assign PayloadStrb    = r_pstrb;
    assign PayloadValid   = r_pvalid;
    assign PayloadFirst   = r_pfirst;
    assign PayloadLast    = r_plast;
    assign PayloadErr     = r_perr;
    assign FrameDropped   = r_drop;
    assign GoodFrameCount = r_good_cnt;
    assign DropFrameCount = r_drop_cnt;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Header parse, accept/drop decision, two-byte realignment and all registered outputs
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_state     <= HDR0;
            r_hold      <= '0;
            r_hold_strb <= '0;
            r_mis       <= 1'b0;
            r_first     <= 1'b0;
            r_user      <= 1'b0;
            r_pdata     <= '0;
            r_pstrb     <= '0;
            r_pvalid    <= 1'b0;
            r_pfirst    <= 1'b0;
            r_plast     <= 1'b0;
            r_perr      <= 1'b0;
            r_drop      <= 1'b0;
            r_good_cnt  <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_pvalid <= 1'b0;
            r_pfirst <= 1'b0;
            r_plast  <= 1'b0;
            r_perr   <= 1'b0;
            r_drop   <= 1'b0;
            if (r_state == FLUSH) begin
                r_pdata    <= {16'h0, r_hold};
                r_pstrb    <= {2'b00, r_hold_strb};
                r_pvalid   <= 1'b1;
                r_plast    <= 1'b1;
                r_perr     <= r_user;
                r_good_cnt <= sat_inc(r_good_cnt);
                r_state    <= HDR0;
            end
            if (RvviAxiRvalid) begin
                case (r_state)
                    HDR0, FLUSH: begin
                        r_mis <= w_mis0;
                        if (RvviAxiRlast) begin
                            r_drop     <= 1'b1;
                            r_drop_cnt <= sat_inc(r_drop_cnt);
                            r_state    <= HDR0;
                        end else begin
                            r_state <= HDR1;
                        end
                    end
                    HDR1: begin
                        r_mis <= r_mis | w_mis1;
                        if (RvviAxiRlast) begin
                            r_drop     <= 1'b1;
                            r_drop_cnt <= sat_inc(r_drop_cnt);
                            r_state    <= HDR0;
                        end else begin
                            r_state <= HDR2;
                        end
                    end
                    HDR2: begin
                        r_mis <= r_mis | w_mis2;
                        if (RvviAxiRlast) begin
                            r_drop     <= 1'b1;
                            r_drop_cnt <= sat_inc(r_drop_cnt);
                            r_state    <= HDR0;
                        end else begin
                            r_state <= HDR3;
                        end
                    end
                    HDR3: begin
                        if (w_runt3 || r_mis || w_mis3) begin
                            r_drop     <= 1'b1;
                            r_drop_cnt <= sat_inc(r_drop_cnt);
                            r_state    <= RvviAxiRlast ? HDR0 : DROP;
                        end else if (RvviAxiRlast) begin
                            r_pdata    <= {16'h0, RvviAxiRdata[31:16]};
                            r_pstrb    <= {2'b00, RvviAxiRstrb[3:2]};
                            r_pvalid   <= 1'b1;
                            r_pfirst   <= 1'b1;
                            r_plast    <= 1'b1;
                            r_perr     <= RvviAxiRuser;
                            r_good_cnt <= sat_inc(r_good_cnt);
                            r_state    <= HDR0;
                        end else begin
                            r_hold      <= RvviAxiRdata[31:16];
                            r_hold_strb <= RvviAxiRstrb[3:2];
                            r_first     <= 1'b1;
                            r_state     <= PAY;
                        end
                    end
                    PAY: begin
                        r_pdata     <= {RvviAxiRdata[15:0], r_hold};
                        r_pstrb     <= {RvviAxiRstrb[1:0], r_hold_strb};
                        r_pvalid    <= 1'b1;
                        r_pfirst    <= r_first;
                        r_first     <= 1'b0;
                        r_hold      <= RvviAxiRdata[31:16];
                        r_hold_strb <= RvviAxiRstrb[3:2];
                        if (RvviAxiRlast && RvviAxiRstrb[3:2] != 2'b00) begin
                            r_user  <= RvviAxiRuser;
                            r_state <= FLUSH;
                        end else if (RvviAxiRlast) begin
                            r_plast    <= 1'b1;
                            r_perr     <= RvviAxiRuser;
                            r_good_cnt <= sat_inc(r_good_cnt);
                            r_state    <= HDR0;
                        end
                    end
                    DROP: begin
                        if (RvviAxiRlast) r_state <= HDR0;
                    end
                    default: r_state <= HDR0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rxframefilter.sv
// tb_rxframefilter: table-driven cycle-accurate check of rxframefilter plus saturation and mid-frame reset sequences
module tb_rxframefilter;
    localparam int CW = 4;
    localparam logic [31:0] W0  = 32'h44332211;
    localparam logic [31:0] W1  = 32'hBBAA6655;
    localparam logic [31:0] W2  = 32'hFFEEDDCC;
    localparam logic [31:0] W3G = 32'h02015C00;
    localparam logic [31:0] W3B = 32'h02010008;

    logic          m_axi_aclk = 1'b0;
    logic          m_axi_aresetn = 1'b0;
    logic [31:0]   RvviAxiRdata = '0;
    logic [3:0]    RvviAxiRstrb = '0;
    logic          RvviAxiRlast = 1'b0;
    logic          RvviAxiRvalid = 1'b0;
    logic          RvviAxiRuser = 1'b0;
    logic [47:0]   DstMac = 48'h112233445566;
    logic [47:0]   SrcMac = 48'hAABBCCDDEEFF;
    logic [15:0]   EthType = 16'h005C;
    logic          FilterEn = 1'b1;
    logic [31:0]   PayloadData;
    logic [3:0]    PayloadStrb;
    logic          PayloadValid;
    logic          PayloadFirst;
    logic          PayloadLast;
    logic          PayloadErr;
    logic          FrameDropped;
    logic [CW-1:0] GoodFrameCount;
    logic [CW-1:0] DropFrameCount;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
        logic        u;
        logic        fe;
        logic        ov;
        logic [31:0] od;
        logic [3:0]  os;
        logic        ofirst;
        logic        olast;
        logic        oerr;
        logic        odrop;
    } vec_t;

    vec_t vecs[$];

    rxframefilter #(.COUNT_WIDTH(CW)) dut (
        .m_axi_aclk    (m_axi_aclk),
        .m_axi_aresetn (m_axi_aresetn),
        .RvviAxiRdata  (RvviAxiRdata),
        .RvviAxiRstrb  (RvviAxiRstrb),
        .RvviAxiRlast  (RvviAxiRlast),
        .RvviAxiRvalid (RvviAxiRvalid),
        .RvviAxiRuser  (RvviAxiRuser),
        .DstMac        (DstMac),
        .SrcMac        (SrcMac),
        .EthType       (EthType),
        .FilterEn      (FilterEn),
        .PayloadData   (PayloadData),
        .PayloadStrb   (PayloadStrb),
        .PayloadValid  (PayloadValid),
        .PayloadFirst  (PayloadFirst),
        .PayloadLast   (PayloadLast),
        .PayloadErr    (PayloadErr),
        .FrameDropped  (FrameDropped),
        .GoodFrameCount(GoodFrameCount),
        .DropFrameCount(DropFrameCount)
    );

    always #5 m_axi_aclk = ~m_axi_aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [31:0] d, input logic [3:0] s, input logic l,
                       input logic u, input logic fe, input logic ov, input logic [31:0] od,
                       input logic [3:0] os, input logic ofirst, input logic olast,
                       input logic oerr, input logic odrop);
        vec_t t;
        t = '{v, d, s, l, u, fe, ov, od, os, ofirst, olast, oerr, odrop};
        vecs.push_back(t);
    endtask

    task automatic quiet(input logic [31:0] d, input logic [3:0] s, input logic l, input logic fe);
        add(1'b1, d, s, l, 1'b0, fe, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        add(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hdr(input logic fe);
        quiet(W0, 4'hF, 1'b0, fe);
        quiet(W1, 4'hF, 1'b0, fe);
        quiet(W2, 4'hF, 1'b0, fe);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] s, input logic l,
                         input logic u, input logic fe);
        RvviAxiRvalid = v;
        RvviAxiRdata  = d;
        RvviAxiRstrb  = s;
        RvviAxiRlast  = l;
        RvviAxiRuser  = u;
        FilterEn      = fe;
        @(posedge m_axi_aclk);
        #1;
    endtask

    task automatic run_vec(input int i);
        vec_t t;
        t = vecs[i];
        drive(t.v, t.d, t.s, t.l, t.u, t.fe);
        chk($sformatf("vec%0d ctl{valid,first,last,err,drop}", i),
            {59'h0, PayloadValid, PayloadFirst, PayloadLast, PayloadErr, FrameDropped},
            {59'h0, t.ov, t.ofirst, t.olast, t.oerr, t.odrop});
        if (t.ov)
            chk($sformatf("vec%0d data/strb", i), {28'h0, PayloadData, PayloadStrb}, {28'h0, t.od, t.os});
    endtask

    initial begin
        // A: 8-byte payload 01..08 (records 0..6)
        hdr(1'b1);
        quiet(W3G, 4'hF, 1'b0, 1'b1);
        add(1, 32'h06050403, 4'hF, 0, 0, 1, 1, 32'h04030201, 4'hF, 1, 0, 0, 0);
        add(1, 32'h00000807, 4'h3, 1, 0, 1, 1, 32'h08070605, 4'hF, 0, 1, 0, 0);
        idle();
        // B: 5-byte payload with MAC bad flag, needs FLUSH
        hdr(1'b1);
        quiet(W3G, 4'hF, 1'b0, 1'b1);
        add(1, 32'h00050403, 4'h7, 1, 1, 1, 1, 32'h04030201, 4'hF, 1, 0, 0, 0);
        add(0, '0, '0, 0, 0, 1, 1, 32'h00000005, 4'h1, 0, 1, 1, 0);
        idle();
        // C: wrong EtherType with filtering, dropped at W3, rest discarded
        hdr(1'b1);
        add(1, W3B, 4'hF, 0, 0, 1, 0, '0, '0, 0, 0, 0, 1);
        quiet(32'h06050403, 4'hF, 1'b1, 1'b1);
        idle();
        // D: same frame with filtering off, accepted; last beat has upper lanes -> FLUSH
        hdr(1'b0);
        quiet(W3B, 4'hF, 1'b0, 1'b0);
        add(1, 32'h06050403, 4'hF, 1, 0, 0, 1, 32'h04030201, 4'hF, 1, 0, 0, 0);
        add(0, '0, '0, 0, 0, 1, 1, 32'h00000605, 4'h3, 0, 1, 0, 0);
        // E: 10-byte runt ending on W2
        quiet(W0, 4'hF, 1'b0, 1'b1);
        quiet(W1, 4'hF, 1'b0, 1'b1);
        add(1, W2, 4'h3, 1, 0, 1, 0, '0, '0, 0, 0, 0, 1);
        idle();
        // F then G: G's W0 arrives in F's FLUSH cycle
        hdr(1'b1);
        quiet(W3G, 4'hF, 1'b0, 1'b1);
        add(1, 32'h00050403, 4'h7, 1, 0, 1, 1, 32'h04030201, 4'hF, 1, 0, 0, 0);
        add(1, W0, 4'hF, 0, 0, 1, 1, 32'h00000005, 4'h1, 0, 1, 0, 0);
        quiet(W1, 4'hF, 1'b0, 1'b1);
        quiet(W2, 4'hF, 1'b0, 1'b1);
        quiet(W3G, 4'hF, 1'b0, 1'b1);
        add(1, 32'h06050403, 4'hF, 0, 0, 1, 1, 32'h04030201, 4'hF, 1, 0, 0, 0);
        add(1, 32'h00000807, 4'h3, 1, 0, 1, 1, 32'h08070605, 4'hF, 0, 1, 0, 0);
        idle();
        // H: destination mismatch in W0, frame ends on W3
        quiet(32'h44332299, 4'hF, 1'b0, 1'b1);
        quiet(W1, 4'hF, 1'b0, 1'b1);
        quiet(W2, 4'hF, 1'b0, 1'b1);
        add(1, W3G, 4'hF, 1, 0, 1, 0, '0, '0, 0, 0, 0, 1);
        idle();
        // I: 16-byte frame, payload entirely inside W3
        hdr(1'b1);
        add(1, W3G, 4'hF, 1, 0, 1, 1, 32'h00000201, 4'h3, 1, 1, 0, 0);
        idle();

        repeat (3) @(posedge m_axi_aclk);
        #1;
        chk("reset outputs", {PayloadData, PayloadStrb, PayloadValid, PayloadFirst, PayloadLast,
                              PayloadErr, FrameDropped, GoodFrameCount, DropFrameCount}, '0);
        @(negedge m_axi_aclk);
        m_axi_aresetn = 1'b1;
        @(posedge m_axi_aclk);
        #1;

        for (int i = 0; i < vecs.size(); i++) run_vec(i);
        chk("good count after table", {60'h0, GoodFrameCount}, 64'd6);
        chk("drop count after table", {60'h0, DropFrameCount}, 64'd3);

        for (int k = 0; k < 20; k++) begin
            drive(1'b1, W0, 4'hF, 1'b1, 1'b0, 1'b1);
            chk($sformatf("sat drop pulse %0d", k), {63'h0, FrameDropped}, 64'd1);
            chk($sformatf("sat drop count %0d", k), {60'h0, DropFrameCount},
                (k + 4 > 15) ? 64'd15 : 64'(k + 4));
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++) run_vec(i);
        RvviAxiRvalid = 1'b0;
        #2;
        m_axi_aresetn = 1'b0;
        #1;
        chk("async reset outputs", {PayloadData, PayloadStrb, PayloadValid, PayloadFirst, PayloadLast,
                                    PayloadErr, FrameDropped, GoodFrameCount, DropFrameCount}, '0);
        @(negedge m_axi_aclk);
        @(negedge m_axi_aclk);
        m_axi_aresetn = 1'b1;
        @(posedge m_axi_aclk);
        #1;
        for (int i = 0; i < 7; i++) run_vec(i);
        chk("good count after reset", {60'h0, GoodFrameCount}, 64'd1);
        chk("drop count after reset", {60'h0, DropFrameCount}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
